// File: rtl/gcd_pkg.sv
// Shared types for the GCD scheduler: FSM state encoding and default operand width.
package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        WAIT,
        DONE
    } state_e;

    localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/gcd_scheduler_if.sv
// Requester bus plus GCD core port, as seen by the scheduler (slave) and its environment (master).
interface gcd_scheduler_if
    import gcd_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = DefaultWidth
) ();

    logic [N-1:0]   req;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [N-1:0]   ack;
    logic [N-1:0]   done;
    logic [W-1:0]   res;
    logic           busy;
    logic           core_start;
    logic [W-1:0]   core_a;
    logic [W-1:0]   core_b;
    logic           core_ready;
    logic [W-1:0]   core_out;

    modport slave (
        input  req, a, b, core_ready, core_out,
        output ack, done, res, busy, core_start, core_a, core_b
    );

    modport master (
        output req, a, b, core_ready, core_out,
        input  ack, done, res, busy, core_start, core_a, core_b
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so pointer+1 lands at bit 0, then
// priority-encode the lowest set bit and map it back to a requester id.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    output logic          grant_valid,
    output logic [IW-1:0] grant_id
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int unsigned    start;

    always_comb begin
        start       = (32'(pointer) + 32'd1) % N;
        dbl         = {req, req};
        rot         = N'(dbl >> start);
        grant_valid = |rot;
        grant_id    = '0;
        // Descending scan so the lowest rotated index wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                grant_id = IW'((start + 32'(i)) % N);
            end
        end
    end

endmodule

// File: rtl/gcd_scheduler.sv
// Shares one subtractive GCD core between N requesters, one request at a time, in
// round-robin order. Zero operands bypass the core since it never terminates on them.
module gcd_scheduler
    import gcd_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = DefaultWidth
) (
    input  logic            clk,
    input  logic            nrst,
    gcd_scheduler_if.slave  bus
);

    localparam int unsigned IW = $clog2(N);

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] id_q, id_d;
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [W-1:0]  result_q, result_d;
    logic [N-1:0]  ack_q, ack_d;
    logic [N-1:0]  done_q, done_d;
    logic [W-1:0]  res_q, res_d;

    logic          grant_valid;
    logic [IW-1:0] grant_id;
    logic [N-1:0]  grant_oh;
    logic [N-1:0]  id_oh;
    logic [W-1:0]  sel_a, sel_b;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req         (bus.req),
        .pointer     (ptr_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        grant_oh = '0;
        id_oh    = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_id == IW'(i)) begin
                sel_a       = bus.a[i*W +: W];
                sel_b       = bus.b[i*W +: W];
                grant_oh[i] = 1'b1;
            end
            if (id_q == IW'(i)) begin
                id_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        ack_d    = '0;
        done_d   = '0;
        res_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_valid && bus.core_ready) begin
                    opa_d = sel_a;
                    opb_d = sel_b;
                    id_d  = grant_id;
                    ack_d = grant_oh;
                    if (sel_a != '0 && sel_b != '0) begin
                        state_d = LAUNCH;
                    end else begin
                        // gcd(x,0)=x, gcd(0,y)=y, gcd(0,0)=0
                        result_d = sel_a | sel_b;
                        state_d  = DONE;
                    end
                end
            end
            LAUNCH: state_d = SETTLE;
            // Core still shows the previous ready for one cycle after the start edge.
            SETTLE: state_d = WAIT;
            WAIT: begin
                if (bus.core_ready) begin
                    result_d = bus.core_out;
                    state_d  = DONE;
                end
            end
            DONE: begin
                done_d  = id_oh;
                res_d   = result_q;
                ptr_d   = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            ptr_q    <= IW'(N - 1);
            id_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            ack_q    <= '0;
            done_q   <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            res_q    <= res_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.done       = done_q;
    assign bus.res        = res_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.core_start = (state_q == LAUNCH);
    assign bus.core_a     = opa_q;
    assign bus.core_b     = opb_q;

endmodule

// File: tb/tb_gcd_scheduler.sv
// Directed bench for gcd_scheduler with a behavioural subtractive GCD core attached.
module tb_gcd_scheduler;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic clk;
    logic nrst;
    logic hold_busy;

    gcd_scheduler_if #(.N(N), .W(W)) bus ();

    gcd_scheduler #(.N(N), .W(W)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: ready falls one cycle after the start edge, then one subtraction per cycle.
    logic         c_pend, c_run, c_rdy;
    logic [W-1:0] c_x, c_y, c_out;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            c_pend <= 1'b0;
            c_run  <= 1'b0;
            c_rdy  <= 1'b1;
            c_x    <= '0;
            c_y    <= '0;
            c_out  <= '0;
        end else if (c_pend) begin
            c_pend <= 1'b0;
            c_run  <= 1'b1;
            c_rdy  <= 1'b0;
        end else if (c_run) begin
            if (c_x == c_y) begin
                c_out <= c_x;
                c_rdy <= 1'b1;
                c_run <= 1'b0;
            end else if (c_x > c_y) begin
                c_x <= c_x - c_y;
            end else begin
                c_y <= c_y - c_x;
            end
        end else if (bus.core_start) begin
            c_x    <= bus.core_a;
            c_y    <= bus.core_b;
            c_pend <= 1'b1;
        end
    end

    assign bus.core_ready = c_rdy & ~hold_busy;
    assign bus.core_out   = c_out;

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;
    int n_viol   = 0;
    int exp_starts = 0;

    always @(negedge clk) begin
        if (nrst && bus.core_start) n_starts++;
        if ($countones(bus.ack) > 1 || $countones(bus.done) > 1) n_viol++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, output logic [N-1:0] d, output logic [W-1:0] r);
        d = '0;
        r = '0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (bus.done != '0) begin
                d = bus.done;
                r = bus.res;
                break;
            end
        end
    endtask

    task automatic set_ops(input int id, input logic [W-1:0] va, input logic [W-1:0] vb);
        bus.a[id*W +: W] = va;
        bus.b[id*W +: W] = vb;
    endtask

    // Single request from an idle scheduler; checks ack/start at cycle 1 and the result.
    task automatic serve(input int id, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] exp, input string tag);
        logic         zero;
        logic [N-1:0] d;
        logic [W-1:0] r;
        zero = (va == '0) || (vb == '0);
        set_ops(id, va, vb);
        bus.req[id] = 1'b1;
        step();
        check({tag, "_ack"}, 32'(bus.ack), 32'd1 << id);
        check({tag, "_start"}, 32'(bus.core_start), zero ? 32'd0 : 32'd1);
        bus.req[id] = 1'b0;
        if (zero) begin
            step();
            d = bus.done;
            r = bus.res;
            check({tag, "_nostart"}, 32'(bus.core_start), 32'd0);
        end else begin
            exp_starts++;
            wait_done(600, d, r);
        end
        check({tag, "_done"}, 32'(d), 32'd1 << id);
        check({tag, "_res"}, 32'(r), 32'(exp));
    endtask

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[6];
    int   rot_order[6];
    logic [W-1:0] rot_exp[N];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] d;
        logic [W-1:0] r;

        // a=b=7 follows 12/18 so a premature exit would return the stale 6.
        vecs[0] = '{1, 8'd12, 8'd18, 8'd6};
        vecs[1] = '{2, 8'd0,  8'd9,  8'd9};
        vecs[2] = '{2, 8'd0,  8'd0,  8'd0};
        vecs[3] = '{0, 8'd7,  8'd7,  8'd7};
        vecs[4] = '{3, 8'd40, 8'd0,  8'd40};
        vecs[5] = '{0, 8'd35, 8'd21, 8'd7};
        rot_order = '{0, 1, 2, 3, 0, 1};
        rot_exp   = '{8'd4, 8'd3, 8'd5, 8'd7};

        nrst      = 1'b0;
        hold_busy = 1'b0;
        bus.req   = '0;
        bus.a     = '0;
        bus.b     = '0;
        step();
        step();
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_res", 32'(bus.res), 0);
        check("rst_start", 32'(bus.core_start), 0);
        check("rst_core_a", 32'(bus.core_a), 0);
        nrst = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            serve(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Pointer is now 0: requesters 0 and 3 together must serve 3 first.
        set_ops(0, 8'd10, 8'd4);
        set_ops(3, 8'd0, 8'd5);
        bus.req = 4'b1001;
        exp_starts++;
        wait_done(600, d, r);
        check("ptr_first_id", 32'(d), 32'b1000);
        check("ptr_first_res", 32'(r), 5);
        bus.req[3] = 1'b0;
        wait_done(600, d, r);
        check("ptr_second_id", 32'(d), 32'b0001);
        check("ptr_second_res", 32'(r), 2);
        bus.req[0] = 1'b0;

        // Core externally busy: request must wait in IDLE.
        hold_busy = 1'b1;
        set_ops(2, 8'd6, 8'd4);
        bus.req[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("blk_ack", 32'(bus.ack), 0);
            check("blk_busy", 32'(bus.busy), 0);
        end
        hold_busy = 1'b0;
        step();
        check("blk_grant", 32'(bus.ack), 32'b0100);
        bus.req[2] = 1'b0;
        exp_starts++;
        wait_done(600, d, r);
        check("blk_done", 32'(d), 32'b0100);
        check("blk_res", 32'(r), 2);

        // Fresh reset so the pointer is N-1, then continuous load from all four.
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        set_ops(0, 8'd12, 8'd8);
        set_ops(1, 8'd9, 8'd6);
        set_ops(2, 8'd25, 8'd15);
        set_ops(3, 8'd14, 8'd21);
        bus.req = '1;
        for (int k = 0; k < 6; k++) begin
            exp_starts++;
            wait_done(600, d, r);
            check($sformatf("rot%0d_id", k), 32'(d), 32'd1 << rot_order[k]);
            check($sformatf("rot%0d_res", k), 32'(r), 32'(rot_exp[rot_order[k]]));
        end
        bus.req = '0;
        step();
        check("rot_idle", 32'(bus.busy), 0);

        // Reset while the core grinds through 255/1.
        set_ops(0, 8'd255, 8'd1);
        bus.req[0] = 1'b1;
        step();
        check("wrst_ack", 32'(bus.ack), 1);
        bus.req[0] = 1'b0;
        exp_starts++;
        for (int i = 0; i < 4; i++) step();
        check("wrst_busy_pre", 32'(bus.busy), 1);
        nrst = 1'b0;
        #1;
        check("wrst_busy", 32'(bus.busy), 0);
        check("wrst_res", 32'(bus.res), 0);
        check("wrst_start", 32'(bus.core_start), 0);
        check("wrst_core_a", 32'(bus.core_a), 0);
        check("wrst_core_b", 32'(bus.core_b), 0);
        step();
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wrst_nodone", 32'(bus.done), 0);
        end
        serve(0, 8'd255, 8'd1, 8'd1, "wrst_retry");

        check("start_count", 32'(n_starts), 32'(exp_starts));
        check("onehot", 32'(n_viol), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
